// File: rtl/lock_pkg.sv
// Shared types and helpers for the locked adder datapath key path.
package lock_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} key_ld_state_t;

   // Default key width, shared with the oracle/adder wrapper.
   localparam int unsigned KEY_W = 2;
   localparam int unsigned KEY_W_MAX = 64;

   // Even-parity reduction; narrower keys are zero-extended by the caller.
   function automatic logic key_parity(input logic [KEY_W_MAX-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Indexed key assembly register: one bit written per accepted beat, LSB first.
module key_shift_reg
   import lock_pkg::*;
#(
   parameter int unsigned KEY_W = lock_pkg::KEY_W,
   parameter int unsigned CNT_W = $clog2(KEY_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             we,
   input  logic [CNT_W-1:0] idx,
   input  logic             data,
   output logic [KEY_W-1:0] q
);

   logic [KEY_W-1:0] q_q;
   logic [KEY_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clear) begin
         q_d = '0;
      end else if (we) begin
         for (int i = 0; i < int'(KEY_W); i++) begin
            if (idx == CNT_W'(i)) q_d[i] = data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/key_loader.sv
// Serial unlock-key loader with trailing even-parity check and atomic commit.
// Define KEY_OTP_EN to make the key one-time-programmable until reset.
module key_loader
   import lock_pkg::*;
#(
   parameter int unsigned KEY_W = lock_pkg::KEY_W,
   parameter int unsigned CNT_W = $clog2(KEY_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             key_bit,
   input  logic             key_valid,
   output logic             key_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_ok,
   output logic             busy,
   output logic             err
);

   key_ld_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] key_out_q, key_out_d;
   logic             key_ok_q, key_ok_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             sr_clear, sr_we;
   logic [KEY_W-1:0] sr_q;
   logic [KEY_W_MAX-1:0] sr_ext;
   logic             accept;
   logic             start_ok;

`ifdef KEY_OTP_EN
   logic otp_done_q, otp_done_d;
   assign start_ok = load_start && !otp_done_q;
`else
   assign start_ok = load_start;
`endif

   assign key_ready = (state_q != IDLE);
   assign accept    = key_valid && key_ready;

   key_shift_reg #(
      .KEY_W (KEY_W),
      .CNT_W (CNT_W)
   ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (sr_clear),
      .we    (sr_we),
      .idx   (cnt_q),
      .data  (key_bit),
      .q     (sr_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      key_out_d = key_out_q;
      key_ok_d  = key_ok_q;
      busy_d    = busy_q;
      err_d     = err_q;
      sr_clear  = 1'b0;
      sr_we     = 1'b0;
      sr_ext    = '0;
      sr_ext[KEY_W-1:0] = sr_q;
`ifdef KEY_OTP_EN
      otp_done_d = otp_done_q;
`endif

      // A start in any state (re)begins a load; a beat in the same cycle is dropped.
      if ((state_q == IDLE) ? start_ok : load_start) begin
         state_d  = SHIFT;
         cnt_d    = '0;
         sr_clear = 1'b1;
         busy_d   = 1'b1;
         err_d    = 1'b0;
         key_ok_d = 1'b0;
      end else begin
         unique case (state_q)
            SHIFT: begin
               if (accept) begin
                  sr_we = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(KEY_W - 1)) state_d = PARITY;
               end
            end
            PARITY: begin
               if (accept) begin
                  if (!(key_parity(sr_ext) ^ key_bit)) begin
                     key_out_d = sr_q;
                     key_ok_d  = 1'b1;
`ifdef KEY_OTP_EN
                     otp_done_d = 1'b1;
`endif
                  end else begin
                     err_d = 1'b1;
                  end
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         key_out_q <= '0;
         key_ok_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_out_q <= key_out_d;
         key_ok_q  <= key_ok_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

`ifdef KEY_OTP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) otp_done_q <= 1'b0;
      else        otp_done_q <= otp_done_d;
   end
`endif

   assign key_out = key_out_q;
   assign key_ok  = key_ok_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed self-checking bench for key_loader with KEY_W=2.
module tb_key_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_start = 1'b0;
   logic       key_bit = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic [1:0] key_out;
   logic       key_ok;
   logic       busy;
   logic       err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   key_loader #(.KEY_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .key_bit    (key_bit),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_out    (key_out),
      .key_ok     (key_ok),
      .busy       (busy),
      .err        (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic with_beat, input logic b);
      load_start = 1'b1;
      key_valid  = with_beat;
      key_bit    = b;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      key_valid  = 1'b0;
   endtask

   task automatic beat(input logic b);
      key_valid = 1'b1;
      key_bit   = b;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Power-on reset
      #2;
      check("por_key_out", 64'(key_out), 64'd0);
      check("por_key_ok", 64'(key_ok), 64'd0);
      check("por_busy", 64'(busy), 64'd0);
      check("por_ready", 64'(key_ready), 64'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Good load 0,1 parity 1 -> 2'b10
      start(1'b0, 1'b0);
      check("start_busy", 64'(busy), 64'd1);
      check("start_ready", 64'(key_ready), 64'd1);
      beat(1'b0);
      beat(1'b1);
      check("shift_busy", 64'(busy), 64'd1);
      check("shift_ok", 64'(key_ok), 64'd0);
      beat(1'b1);
      check("good_key", 64'(key_out), 64'd2);
      check("good_ok", 64'(key_ok), 64'd1);
      check("good_busy", 64'(busy), 64'd0);
      check("good_err", 64'(err), 64'd0);
      check("good_ready", 64'(key_ready), 64'd0);

      // Back-to-back start, then bad parity 1,1 parity 1
      start(1'b0, 1'b0);
      check("b2b_busy", 64'(busy), 64'd1);
      check("b2b_ok", 64'(key_ok), 64'd0);
      check("b2b_key", 64'(key_out), 64'd2);
      beat(1'b1);
      beat(1'b1);
      beat(1'b1);
      check("bad_err", 64'(err), 64'd1);
      check("bad_ok", 64'(key_ok), 64'd0);
      check("bad_key", 64'(key_out), 64'd2);
      check("bad_busy", 64'(busy), 64'd0);

      // Stall: invalid cycles must not count; 1,(stall),1 parity 0 -> 2'b11
      start(1'b0, 1'b0);
      check("stall_err_clr", 64'(err), 64'd0);
      beat(1'b1);
      key_bit = 1'b0;
      idle(5);
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_ready", 64'(key_ready), 64'd1);
      beat(1'b1);
      beat(1'b0);
      check("stall_key", 64'(key_out), 64'd3);
      check("stall_ok", 64'(key_ok), 64'd1);

      // Restart mid-SHIFT with a discarded concurrent beat; then 1,0 parity 1 -> 2'b01
      start(1'b0, 1'b0);
      beat(1'b0);
      start(1'b1, 1'b1);
      check("restart_busy", 64'(busy), 64'd1);
      check("restart_ok", 64'(key_ok), 64'd0);
      beat(1'b1);
      beat(1'b0);
      check("restart_mid_busy", 64'(busy), 64'd1);
      beat(1'b1);
      check("restart_key", 64'(key_out), 64'd1);
      check("restart_ok2", 64'(key_ok), 64'd1);
      check("restart_busy2", 64'(busy), 64'd0);

      // Asynchronous reset mid-load
      start(1'b0, 1'b0);
      beat(1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_key", 64'(key_out), 64'd0);
      check("arst_ok", 64'(key_ok), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_err", 64'(err), 64'd0);
      check("arst_ready", 64'(key_ready), 64'd0);
      idle(1);
      rst_n = 1'b1;
      idle(1);

      // Reload 0,1 parity 1 -> 2'b10
      start(1'b0, 1'b0);
      beat(1'b0);
      beat(1'b1);
      beat(1'b1);
      check("reload_key", 64'(key_out), 64'd2);
      check("reload_ok", 64'(key_ok), 64'd1);

`ifdef KEY_OTP_EN
      // Locked: start ignored, beats ignored
      start(1'b0, 1'b0);
      check("otp_busy", 64'(busy), 64'd0);
      beat(1'b1);
      beat(1'b1);
      beat(1'b0);
      check("otp_key", 64'(key_out), 64'd2);
      check("otp_ok", 64'(key_ok), 64'd1);
      check("otp_busy2", 64'(busy), 64'd0);
      idle(1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      start(1'b0, 1'b0);
      beat(1'b1);
      beat(1'b1);
      beat(1'b0);
      check("otp_reload_key", 64'(key_out), 64'd3);
      check("otp_reload_ok", 64'(key_ok), 64'd1);
`else
      // Reloadable: 1,1 parity 0 -> 2'b11
      start(1'b0, 1'b0);
      check("multi_busy", 64'(busy), 64'd1);
      beat(1'b1);
      beat(1'b1);
      beat(1'b0);
      check("multi_key", 64'(key_out), 64'd3);
      check("multi_ok", 64'(key_ok), 64'd1);
      check("multi_busy2", 64'(busy), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Upstream stage of the XOR key-gate oracle in the locked adder datapath.
- Receives the unlock key serially over a valid/ready handshake, LSB first.
- Checks one trailing even-parity bit, then commits the assembled key to a stable register.
- The committed register drives the oracle key input `k` and is never partially updated.

Parameters:
- KEY_W, 2: key width in bits; it equals the oracle key width. Legal range is 1..64.
- CNT_W, $clog2(KEY_W+1): width of the beat counter (derived; do not override).

Ports:
- clk  in  1  : system clock, rising edge.
- rst_n  in  1  : asynchronous active-low reset.
- load_start  in  1  : single-cycle pulse that begins a key load.
- key_bit  in  1  : serial key or parity data.
- key_valid  in  1  : key_bit is valid this cycle.
- key_ready  out  1  : loader accepts a beat this cycle.
- key_out  out  KEY_W  : committed key, feeding the oracle `k`.
- key_ok  out  1  : key_out holds a parity-checked key.
- busy  out  1  : a load is in progress.
- err  out  1  : the last load failed its parity check.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - key_out=0, key_ok=0, busy=0, err=0, key_ready=0.
  - Shift register and counter are cleared.
- State machine: IDLE, SHIFT, PARITY. All outputs are registered except key_ready, which decodes directly from state.
- A beat is accepted when key_valid && key_ready at the rising edge.
- IDLE:
  - key_ready=0, busy=0.
  - On load_start, the next state is SHIFT.
  - On that same edge: clear shift register and counter, set busy=1, clear err and key_ok.
  - key_out is retained (it is not zeroed).
- SHIFT:
  - key_ready=1.
  - Each accepted beat writes key_bit into shift register bit [cnt] (LSB first), and cnt increments.
  - The edge that accepts beat KEY_W-1 moves the state to PARITY.
  - key_valid low simply stalls, with no timeout.
- PARITY:
  - key_ready=1.
  - On the accepted beat, compute parity = XOR(shift register) ^ key_bit.
  - If parity == 0 (even):
    - On that same edge, key_out <= shift register and key_ok <= 1.
    - Latency: KEY_W+1 accepted beats; key_out is valid on the edge of the last beat.
  - If parity == 1:
    - err <= 1 and key_ok stays 0.
    - key_out keeps its old value, so the oracle never sees a corrupt key.
  - In both cases: busy <= 0 and the state returns to IDLE.
- load_start while in SHIFT or PARITY:
  - The load aborts and restarts: shift register and counter clear, state goes to SHIFT.
  - busy stays 1, and err and key_ok clear.
  - A beat presented in that same cycle is discarded.
- Reset asserted mid-load: the full reset values above apply immediately, and the partial key is lost.
- key_bit is ignored whenever key_ready=0.

Optional Feature:
- Macro: KEY_OTP_EN.
- Defined (one-time-programmable key):
  - After the first successful commit (key_ok=1), load_start is ignored until rst_n is asserted.
  - key_out, key_ok, busy and err are frozen.
  - A sticky internal otp_done flag, reset to 0, gates the IDLE->SHIFT transition.
  - Failed loads do not set otp_done.
- Undefined: the key is reloadable any number of times, as described above.

Decomposition:
- Package lock_pkg holds:
  - the state typedef key_ld_state_t {IDLE, SHIFT, PARITY};
  - the default KEY_W localparam shared with the oracle/adder wrapper;
  - a parity function on a KEY_W vector.
- Sub-module key_shift_reg:
  - inputs: clear, write enable, bit index, data;
  - output: KEY_W vector.
  - The FSM stays in key_loader.

Test Plan:
- Reset values: assert rst_n=0 mid-run -> key_out=0, key_ok=0, busy=0, err=0 immediately, without waiting for clk.
- Good load, KEY_W=2: pulse load_start, send 0,1 then parity 1 -> key_out=2'b10 and key_ok=1 on the parity edge, busy=0. With the oracle downstream, a=2 gives enca=0.
- Bad parity: load 1,1 then parity 1 -> err=1, key_ok=0, key_out keeps the previous 2'b10.
- Stall and restart:
  - Drop key_valid for 5 cycles mid-SHIFT -> no beat is counted.
  - Then pulse load_start -> counter restarts.
  - Then load 1,0 with parity 1 -> key_out=2'b01.
- Back-to-back: second load_start on the cycle after a commit -> busy=1, key_ok=0, key_out unchanged until the new commit.
- KEY_OTP_EN: after a good commit of 2'b10, pulse load_start and send 1,1 with parity 0 -> busy stays 0 and key_out stays 2'b10; after rst_n, a reload succeeds.
